cbfp_min_cnt_gen: RTL and testbench
===================================

// Module: cbfp_min_cnt_gen
// PURPOSE
// - Producer side of the CBFP block-normalisation interface: measures the redundant sign bits of every sample
//   in a block and emits min_cnt_0/min_cnt_1 for the downstream shift stage.
// - Consumes a 16-lane complex stream, one block = BLOCK_BEATS valid beats.
// - Finds the minimum redundant-sign-bit count per half (lanes 0..HALF-1, lanes HALF..DATA_WIDTH-1) over the whole block.
// - Replays the buffered block with those counts held constant, so data and counts arrive aligned at the shifter.
// PARAMETERS
// - I_WIDTH     24  sample width (re and im), signed two's complement
// - DATA_WIDTH  16  lanes per beat; HALF = DATA_WIDTH/2
// - BLOCK_BEATS 4   valid beats per CBFP block (>=2)
// - CNT_W       5   count width; must satisfy 2**CNT_W > I_WIDTH-1
// PORTS
// - clk         in   1                       single clock, rising edge
// - rst         in   1                       synchronous, active-high reset
// - din_valid   in   1                       beat qualifier; no backpressure
// - din_re      in   [I_WIDTH-1:0] x16       signed real samples
// - din_im      in   [I_WIDTH-1:0] x16       signed imag samples
// - dout_valid  out  1                       replayed beat valid
// - dout_re     out  [I_WIDTH-1:0] x16       buffered real samples, unmodified
// - dout_im     out  [I_WIDTH-1:0] x16       buffered imag samples, unmodified
// - dout_first  out  1                       high on the first beat of a block
// - dout_last   out  1                       high on the last beat of a block
// - min_cnt_0   out  [CNT_W-1:0]             block minimum, lanes 0..HALF-1
// - min_cnt_1   out  [CNT_W-1:0]             block minimum, lanes HALF..DATA_WIDTH-1
// BEHAVIOUR
// - Sample count = number of leading bits equal to the MSB, minus 1; range 0..I_WIDTH-1.
//   - 0 and -1 both give I_WIDTH-1 (23).
//   - 0x400000 and 0xBFFFFF both give 0.
// - Per beat: combinational min over re and im of each half, then a registered running min per half.
//   - The running min is re-seeded (not min'ed) on the first beat of each block.
// - Buffer: ping-pong, 2 banks x BLOCK_BEATS beats.
//   - Write pointer advances on din_valid only; gaps between valid beats are allowed.
//   - On the BLOCK_BEATS-th valid beat the bank and its final min pair are marked FULL, and the write side
//     flips to the other bank.
// - Read FSM states:
//   - IDLE -> PLAY when a bank is FULL.
//   - PLAY emits one beat per cycle for BLOCK_BEATS cycles, then frees the bank.
//   - PLAY -> PLAY if the other bank is already FULL, else PLAY -> IDLE.
// - Latency: first output beat is registered the cycle after the last input beat of the block is sampled.
//   - Continuous input therefore gives continuous output, delayed BLOCK_BEATS+1 cycles.
// - min_cnt_0/1 are loaded at dout_first and held until the next block's dout_first, including while idle.
// - dout_first and dout_last are both valid-qualified. dout_re/dout_im hold their last value when
//   dout_valid=0.
// - Overflow cannot occur, because the read side drains 1 beat/cycle >= the input rate.
//   - Writing into a bank that is still FULL is a protocol error.
//   - Guard it with an assertion; no recovery logic.
// - Simultaneous events: a block completing on the write side in the same cycle that the read side frees
//   the other bank is legal. The freed bank is immediately writable.
// - Reset, including mid-block: next cycle, every output is 0.
//   - Covered outputs: dout_valid, dout_first, dout_last, dout_re, dout_im, min_cnt_0, min_cnt_1.
//   - Both banks return to EMPTY, pointers and running mins are cleared, the FSM goes to IDLE.
//   - Partial blocks are discarded; the first din_valid after reset is beat 0 of a new block.
// STRUCTURE
// - Shared package cbfp_pkg holds:
//   - localparams I_WIDTH, DATA_WIDTH, CNT_W;
//   - typedefs sample_t = logic signed [I_WIDTH-1:0] and cnt_t = logic [CNT_W-1:0];
//   - typedef enum {IDLE, PLAY} cbfp_rd_state_e.
// - One sub-module: cbfp_sign_cnt, a combinational per-sample redundant-sign-bit counter, instantiated
//   2*DATA_WIDTH times.
// - Min trees, ping-pong storage and the read FSM live in this module.
// TESTING
// - Continuous ramp, lane i re = i<<8, im = 0, 4 beats:
//   - min_cnt_0 = 23-11 = 12 (lane 7: 0x700 has 11 significant bits);
//   - min_cnt_1 = 23-12 = 11 (lane 15: 0xF00 has 12 significant bits);
//   - dout equals din, delayed 5 cycles.
// - All-zero block, then a block with lane 9 im = -0x800000 on beat 2:
//   - block A: min_cnt_0 = min_cnt_1 = 23;
//   - block B: min_cnt_0 = 23, min_cnt_1 = 0.
// - din_valid toggled 1010...:
//   - output blocks stay contiguous (4 back-to-back beats);
//   - dout_first and dout_last land on the correct beats;
//   - counts are held between blocks.
// - Back-to-back continuous blocks for 64 cycles: no dout_valid bubbles, no overflow assertion, and both
//   banks are exercised alternately.
// - rst asserted after 2 beats of a block:
//   - outputs are 0 the next cycle;
//   - the following 4 valid beats form a fresh block, with mins computed from those beats only.

Source files
------------

// File: rtl/cbfp_pkg.sv
// Shared definitions for the CBFP min-count generator.
// Holds the datapath geometry, the sample/count typedefs, the read-side
// state encoding and a small min helper used by the min trees.
package cbfp_pkg;

  localparam int I_WIDTH     = 24;
  localparam int DATA_WIDTH  = 16;
  localparam int HALF        = DATA_WIDTH / 2;
  localparam int BLOCK_BEATS = 4;
  localparam int CNT_W       = 5;
  localparam int PTR_W       = (BLOCK_BEATS > 2) ? $clog2(BLOCK_BEATS) : 1;

  typedef logic signed [I_WIDTH-1:0]             sample_t;
  typedef logic [CNT_W-1:0]                      cnt_t;
  typedef logic [PTR_W-1:0]                      ptr_t;
  typedef logic [DATA_WIDTH-1:0][I_WIDTH-1:0]    beat_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PLAY = 1'b1
  } cbfp_rd_state_e;

  // Largest possible count: a sample of all sign bits (0 or -1).
  localparam cnt_t CNT_MAX  = cnt_t'(I_WIDTH - 1);
  localparam ptr_t LAST_PTR = ptr_t'(BLOCK_BEATS - 1);

  function automatic cnt_t cnt_min(input cnt_t a, input cnt_t b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/cbfp_sign_cnt.sv
// Combinational redundant-sign-bit counter for one signed sample.
// The count is the number of bits directly below the MSB that equal the
// MSB, so it ranges 0..I_WIDTH-1 (0 and -1 both give I_WIDTH-1).
// Ports:
//   sample_i  in   [I_WIDTH-1:0]  two's complement sample
//   cnt_o     out  [CNT_W-1:0]    redundant sign bit count
module cbfp_sign_cnt
  import cbfp_pkg::*;
(
  input  logic [I_WIDTH-1:0] sample_i,
  output logic [CNT_W-1:0]   cnt_o
);

  logic [CNT_W-1:0] cnt_s;
  logic             run_s;

  // Walk down from just below the MSB until the first bit that differs.
  always_comb begin
    cnt_s = '0;
    run_s = 1'b1;
    for (int i = I_WIDTH - 2; i >= 0; i--) begin
      if (run_s && (sample_i[i] == sample_i[I_WIDTH-1])) begin
        cnt_s = cnt_s + cnt_t'(1);
      end else begin
        run_s = 1'b0;
      end
    end
  end

  assign cnt_o = cnt_s;

endmodule

// File: rtl/cbfp_min_cnt_gen.sv
// Overflow guard for the ping-pong buffer: the write side must never land a
// beat in a bank that is still waiting to be replayed, except in the cycle
// where the reader is releasing that very bank.
// Ports:
//   clk, rst        clock and synchronous reset
//   din_valid       input beat qualifier
//   wr_full_i       FULL flag of the bank the write side points at
//   wr_freeing_i    reader is freeing that bank this cycle
module cbfp_min_cnt_gen_chk (
  input logic clk,
  input logic rst,
  input logic din_valid,
  input logic wr_full_i,
  input logic wr_freeing_i
);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(din_valid && wr_full_i && !wr_freeing_i));

endmodule

// CBFP min-count generator.
// Measures the redundant sign bits of every sample of a block, keeps the
// block minimum separately for the lower and upper lane halves, and replays
// the buffered block with those minima held constant so data and counts
// reach the downstream shifter together.
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   din_valid, din_re/im     input beats (16 complex lanes), no backpressure
//   dout_valid, dout_re/im   replayed beats, data held while not valid
//   dout_first, dout_last    block boundary markers (valid-qualified)
//   min_cnt_0, min_cnt_1     block minima for lanes 0..7 / 8..15, loaded at
//                            dout_first and held until the next block
module cbfp_min_cnt_gen
  import cbfp_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               din_valid,
  input  logic [DATA_WIDTH-1:0][I_WIDTH-1:0] din_re,
  input  logic [DATA_WIDTH-1:0][I_WIDTH-1:0] din_im,
  output logic                               dout_valid,
  output logic [DATA_WIDTH-1:0][I_WIDTH-1:0] dout_re,
  output logic [DATA_WIDTH-1:0][I_WIDTH-1:0] dout_im,
  output logic                               dout_first,
  output logic                               dout_last,
  output logic [CNT_W-1:0]                   min_cnt_0,
  output logic [CNT_W-1:0]                   min_cnt_1
);

  cnt_t           cnt_re_s [DATA_WIDTH];
  cnt_t           cnt_im_s [DATA_WIDTH];
  cnt_t           beat_min0_s, beat_min1_s;
  cnt_t           blk_min0_s, blk_min1_s;
  cnt_t           run_min0_q, run_min1_q;
  ptr_t           wr_ptr_q, rd_ptr_q;
  logic           wr_bank_q, rd_bank_q;
  logic [1:0]     full_q, full_d;
  logic           wr_done_s, rd_free_s;
  cbfp_rd_state_e state_q;

  beat_t          mem_re_q [2][BLOCK_BEATS];
  beat_t          mem_im_q [2][BLOCK_BEATS];
  cnt_t           bank_min0_q [2];
  cnt_t           bank_min1_q [2];

  for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_lane
    cbfp_sign_cnt u_cnt_re (.sample_i(din_re[g]), .cnt_o(cnt_re_s[g]));
    cbfp_sign_cnt u_cnt_im (.sample_i(din_im[g]), .cnt_o(cnt_im_s[g]));
  end

  // Per-beat minimum over re and im of each lane half.
  always_comb begin
    beat_min0_s = CNT_MAX;
    beat_min1_s = CNT_MAX;
    for (int l = 0; l < HALF; l++) begin
      beat_min0_s = cnt_min(beat_min0_s, cnt_min(cnt_re_s[l], cnt_im_s[l]));
    end
    for (int l = HALF; l < DATA_WIDTH; l++) begin
      beat_min1_s = cnt_min(beat_min1_s, cnt_min(cnt_re_s[l], cnt_im_s[l]));
    end
  end

  // Running block minimum including this beat; beat 0 re-seeds it.
  always_comb begin
    if (wr_ptr_q == '0) begin
      blk_min0_s = beat_min0_s;
      blk_min1_s = beat_min1_s;
    end else begin
      blk_min0_s = cnt_min(run_min0_q, beat_min0_s);
      blk_min1_s = cnt_min(run_min1_q, beat_min1_s);
    end
  end

  assign wr_done_s = din_valid && (wr_ptr_q == LAST_PTR);
  assign rd_free_s = (state_q == PLAY) && (rd_ptr_q == LAST_PTR);

  // Write pointer, bank select and running minima.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      wr_bank_q  <= 1'b0;
      run_min0_q <= '0;
      run_min1_q <= '0;
    end else if (din_valid) begin
      run_min0_q <= blk_min0_s;
      run_min1_q <= blk_min1_s;
      if (wr_done_s) begin
        wr_ptr_q  <= '0;
        wr_bank_q <= ~wr_bank_q;
      end else begin
        wr_ptr_q  <= wr_ptr_q + ptr_t'(1);
      end
    end
  end

  // Beat storage and per-bank final minima; contents are only meaningful
  // while the bank is FULL, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (din_valid && !rst) begin
      mem_re_q[wr_bank_q][wr_ptr_q] <= din_re;
      mem_im_q[wr_bank_q][wr_ptr_q] <= din_im;
    end
    if (wr_done_s && !rst) begin
      bank_min0_q[wr_bank_q] <= blk_min0_s;
      bank_min1_q[wr_bank_q] <= blk_min1_s;
    end
  end

  // FULL flags: the reader frees one bank while the writer may complete the
  // other in the same cycle.
  always_comb begin
    full_d            = full_q;
    full_d[rd_bank_q] = rd_free_s ? 1'b0 : full_q[rd_bank_q];
    full_d[wr_bank_q] = wr_done_s ? 1'b1 : full_d[wr_bank_q];
  end

  // FULL flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 2'b00;
    end else begin
      full_q <= full_d;
    end
  end

  // Read FSM with registered outputs. IDLE launches beat 0 directly so the
  // first replayed beat appears the cycle after the block completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_bank_q  <= 1'b0;
      rd_ptr_q   <= '0;
      dout_valid <= 1'b0;
      dout_first <= 1'b0;
      dout_last  <= 1'b0;
      dout_re    <= '0;
      dout_im    <= '0;
      min_cnt_0  <= '0;
      min_cnt_1  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          dout_last <= 1'b0;
          if (full_q[rd_bank_q]) begin
            dout_valid <= 1'b1;
            dout_first <= 1'b1;
            dout_re    <= mem_re_q[rd_bank_q][ptr_t'(0)];
            dout_im    <= mem_im_q[rd_bank_q][ptr_t'(0)];
            min_cnt_0  <= bank_min0_q[rd_bank_q];
            min_cnt_1  <= bank_min1_q[rd_bank_q];
            rd_ptr_q   <= ptr_t'(1);
            state_q    <= PLAY;
          end else begin
            dout_valid <= 1'b0;
            dout_first <= 1'b0;
          end
        end
        PLAY: begin
          dout_valid <= 1'b1;
          dout_first <= (rd_ptr_q == '0);
          dout_last  <= (rd_ptr_q == LAST_PTR);
          dout_re    <= mem_re_q[rd_bank_q][rd_ptr_q];
          dout_im    <= mem_im_q[rd_bank_q][rd_ptr_q];
          if (rd_ptr_q == '0) begin
            min_cnt_0 <= bank_min0_q[rd_bank_q];
            min_cnt_1 <= bank_min1_q[rd_bank_q];
          end
          if (rd_ptr_q == LAST_PTR) begin
            rd_bank_q <= ~rd_bank_q;
            rd_ptr_q  <= '0;
            if (full_q[~rd_bank_q]) begin
              state_q <= PLAY;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            rd_ptr_q <= rd_ptr_q + ptr_t'(1);
          end
        end
        default: begin
          state_q    <= IDLE;
          rd_ptr_q   <= '0;
          dout_valid <= 1'b0;
          dout_first <= 1'b0;
          dout_last  <= 1'b0;
        end
      endcase
    end
  end

  cbfp_min_cnt_gen_chk u_chk (
    .clk          (clk),
    .rst          (rst),
    .din_valid    (din_valid),
    .wr_full_i    (full_q[wr_bank_q]),
    .wr_freeing_i (rd_free_s && (rd_bank_q == wr_bank_q))
  );

endmodule

// File: tb/tb_cbfp_min_cnt_gen.sv
module tb_cbfp_min_cnt_gen;
  import cbfp_pkg::*;

  typedef struct {
    beat_t re;
    beat_t im;
    logic  first;
    logic  last;
    cnt_t  m0;
    cnt_t  m1;
    int    cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din_valid = 1'b0;
  beat_t      din_re = '0;
  beat_t      din_im = '0;
  logic       dout_valid, dout_first, dout_last;
  beat_t      dout_re, dout_im;
  cnt_t       min_cnt_0, min_cnt_1;

  cbfp_min_cnt_gen dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_re(din_re), .din_im(din_im),
    .dout_valid(dout_valid), .dout_re(dout_re), .dout_im(dout_im),
    .dout_first(dout_first), .dout_last(dout_last),
    .min_cnt_0(min_cnt_0), .min_cnt_1(min_cnt_1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int    errors = 0;
  int    checks = 0;
  exp_t  exp_q[$];
  beat_t blk_re[$];
  beat_t blk_im[$];
  int    prev_last = -100;
  bit    skip_mon = 1'b1;
  int    zero_req = 0;
  int    zero_done = 0;
  beat_t held_re, held_im;
  cnt_t  held_m0, held_m1;
  exp_t  mon_e;

  task automatic chk(input string nm, input logic [383:0] act, input logic [383:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference count: bits needed for the value as a signed number, from its magnitude.
  function automatic int ref_cnt(input logic [I_WIDTH-1:0] x);
    int v, n;
    v = int'($signed(x));
    n = 0;
    while (!((v >= -(1 << n)) && (v < (1 << n)))) n++;
    return (I_WIDTH - 1) - n;
  endfunction

  // Collect a block; once complete, schedule its replay.
  task automatic model_add(input beat_t re, input beat_t im, input int e);
    int m0, m1, c, start;
    blk_re.push_back(re);
    blk_im.push_back(im);
    if (blk_re.size() == BLOCK_BEATS) begin
      m0 = I_WIDTH - 1;
      m1 = I_WIDTH - 1;
      for (int b = 0; b < BLOCK_BEATS; b++) begin
        for (int l = 0; l < DATA_WIDTH; l++) begin
          c = ref_cnt(blk_re[b][l]);
          if (ref_cnt(blk_im[b][l]) < c) c = ref_cnt(blk_im[b][l]);
          if (l < HALF) begin
            if (c < m0) m0 = c;
          end else begin
            if (c < m1) m1 = c;
          end
        end
      end
      start = (e + 2 > prev_last + 1) ? e + 2 : prev_last + 1;
      for (int b = 0; b < BLOCK_BEATS; b++) begin
        exp_q.push_back('{re: blk_re[b], im: blk_im[b], first: (b == 0),
                          last: (b == BLOCK_BEATS - 1), m0: cnt_t'(m0), m1: cnt_t'(m1),
                          cyc: start + b});
      end
      prev_last = start + BLOCK_BEATS - 1;
      blk_re.delete();
      blk_im.delete();
    end
  endtask

  task automatic drive(input bit v, input beat_t re, input beat_t im);
    din_valid = v;
    din_re    = re;
    din_im    = im;
    @(posedge clk);
    if (v) model_add(re, im, cyc);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic do_reset();
    skip_mon  = 1'b1;
    rst       = 1'b1;
    din_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    blk_re.delete();
    blk_im.delete();
    prev_last = -100;
    zero_req++;
    skip_mon = 1'b0;
  endtask

  function automatic logic [I_WIDTH-1:0] rnd_s();
    logic [31:0] r;
    r = $urandom >> $urandom_range(0, 31);
    if ($urandom_range(0, 1) == 1) r = ~r;
    return r[I_WIDTH-1:0];
  endfunction

  function automatic beat_t rnd_beat();
    beat_t b;
    for (int l = 0; l < DATA_WIDTH; l++) b[l] = rnd_s();
    return b;
  endfunction

  // Monitor: reset-zero checks, scoreboard pops on valid, hold checks when idle.
  always @(negedge clk) begin
    if (zero_req != zero_done) begin
      chk("rst_valid", dout_valid, 0);
      chk("rst_first", dout_first, 0);
      chk("rst_last", dout_last, 0);
      chk("rst_re", dout_re, 0);
      chk("rst_im", dout_im, 0);
      chk("rst_min0", min_cnt_0, 0);
      chk("rst_min1", min_cnt_1, 0);
      held_re = '0;
      held_im = '0;
      held_m0 = '0;
      held_m1 = '0;
      zero_done++;
    end else if (!skip_mon) begin
      if (dout_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", dout_valid, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat_cycle", cyc, mon_e.cyc);
          chk("dout_re", dout_re, mon_e.re);
          chk("dout_im", dout_im, mon_e.im);
          chk("dout_first", dout_first, mon_e.first);
          chk("dout_last", dout_last, mon_e.last);
          chk("min_cnt_0", min_cnt_0, mon_e.m0);
          chk("min_cnt_1", min_cnt_1, mon_e.m1);
          held_re = mon_e.re;
          held_im = mon_e.im;
          held_m0 = mon_e.m0;
          held_m1 = mon_e.m1;
        end
      end else begin
        chk("idle_first", dout_first, 0);
        chk("idle_last", dout_last, 0);
        chk("hold_re", dout_re, held_re);
        chk("hold_im", dout_im, held_im);
        chk("hold_min0", min_cnt_0, held_m0);
        chk("hold_min1", min_cnt_1, held_m1);
      end
    end
  end

  initial begin
    beat_t re, im;
    int nv;
    do_reset();

    // Ramp: lane i re = i<<8, im = 0.
    for (int b = 0; b < BLOCK_BEATS; b++) begin
      for (int l = 0; l < DATA_WIDTH; l++) re[l] = 24'(l << 8);
      drive(1'b1, re, '0);
    end
    repeat (8) drive(1'b0, '0, '0);

    // All-zero block, then a single full-scale negative sample in lane 9 im.
    for (int b = 0; b < BLOCK_BEATS; b++) drive(1'b1, '0, '0);
    for (int b = 0; b < BLOCK_BEATS; b++) begin
      im = '0;
      if (b == 2) im[9] = 24'h800000;
      drive(1'b1, '0, im);
    end
    repeat (8) drive(1'b0, '0, '0);

    // Alternating valid.
    for (int k = 0; k < 4 * BLOCK_BEATS; k++) drive((k % 2) == 0, rnd_beat(), rnd_beat());
    repeat (3) drive(1'b0, '0, '0);

    // Back-to-back blocks for 64 cycles.
    for (int k = 0; k < 64; k++) drive(1'b1, rnd_beat(), rnd_beat());
    repeat (12) drive(1'b0, '0, '0);

    // Reset two beats into a block; the next four beats form a fresh block.
    drive(1'b1, rnd_beat(), rnd_beat());
    drive(1'b1, '0, {DATA_WIDTH{24'h800000}});
    do_reset();
    for (int b = 0; b < BLOCK_BEATS; b++) drive(1'b1, rnd_beat(), rnd_beat());
    repeat (8) drive(1'b0, '0, '0);

    // Random gaps.
    nv = 0;
    while (nv < 3 * BLOCK_BEATS) begin
      if ($urandom_range(0, 2) != 0) begin
        drive(1'b1, rnd_beat(), rnd_beat());
        nv++;
      end else begin
        drive(1'b0, rnd_beat(), rnd_beat());
      end
    end

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) drive(1'b0, '0, '0);
    chk("drain_empty", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
